// File: rtl/ts_cdc_fifo_lvl.sv
// ts_cdc_fifo_lvl
//   Dual-clock FIFO for TS byte streams ([9:2]=DATA, [1]=VALID, [0]=SYNC).
//   It carries them from the MUX/PCR stages into the 27 MHz output domain.
//   Pointers cross domains in Gray code through SYNC_STAGES-deep synchronisers.
//   Each side keeps a registered, pessimistic fill level plus almost flags.
//   Sticky overflow and underflow flags are set on rejected requests.
//   If a set and a clear of a sticky flag land in the same cycle, the set wins.
//
// Optional feature macro: TS_CDC_FIFO_FWFT_EN
//   defined   -> first-word-fall-through. rdata already holds the head word
//                whenever empty=0, and r_en moves on to the next word.
//   undefined -> standard mode. rdata is registered one rclk after r_en.
//
// Ports
//   wclk, rclk      write / read clocks
//   rst             async, active-high reset for both domains; deassertion
//                   is synchronised separately in each domain
//   w_en, wdata     write request and data (wclk)
//   ovf_clr         clear sticky overflow (wclk)
//   full            no free entry (wclk)
//   almost_full     wr_level >= AF_THRESH
//   wr_level        write-side occupancy, never below the true value
//   overflow        sticky: write attempted while full
//   r_en, udf_clr   read request, clear sticky underflow (rclk)
//   rdata           read data, holds its value when no read occurs
//   empty           no readable word (rclk)
//   almost_empty    rd_level <= AE_THRESH
//   rd_level        read-side occupancy, never above the true value
//   underflow       sticky: read attempted while empty
module ts_cdc_fifo_lvl #(
  parameter int DATA_WIDTH  = 10,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 2
) (
  input  logic                  wclk,
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  r_en,
  input  logic                  udf_clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

  generate
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("ts_cdc_fifo_lvl: SYNC_STAGES must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
      $error("ts_cdc_fifo_lvl: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
      $error("ts_cdc_fifo_lvl: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [1:0]            wrst_sync, rrst_sync;
  logic                  wrst, rrst;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wbin, wgray, wbin_next;
  logic [PW-1:0]         rbin, rgray, rbin_next;
  logic [PW-1:0]         rgray_w [SYNC_STAGES];
  logic [PW-1:0]         wgray_r [SYNC_STAGES];
  logic [PW-1:0]         wsync_bin;
  logic                  w_push;

  // Reset is applied at once but released only on a clock edge of each
  // domain, so no flop leaves reset right next to an edge.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) wrst_sync <= 2'b00;
    else     wrst_sync <= {wrst_sync[0], 1'b1};
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) rrst_sync <= 2'b00;
    else     rrst_sync <= {rrst_sync[0], 1'b1};
  end

  assign wrst = ~wrst_sync[1];
  assign rrst = ~rrst_sync[1];

  // ---------------- write domain ----------------
  assign w_push      = w_en && !full;
  assign wbin_next   = wbin + PW'(w_push);
  assign full        = (wr_level == DEPTH_L);
  assign almost_full = (wr_level >= AF_L);

  // The level uses the post-write pointer, so full rises on the same edge
  // that stores the last free word. The read pointer seen here is stale,
  // which can only make the level look higher than it really is.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin     <= '0;
      wgray    <= '0;
      wr_level <= '0;
      overflow <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= bin2gray(wbin_next);
      wr_level <= wbin_next - gray2bin(rgray_w[SYNC_STAGES-1]);
      if (w_en && full) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Read pointer (Gray) into the write domain.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rgray_w[i] <= '0;
    end else begin
      rgray_w[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_w[i] <= rgray_w[i-1];
    end
  end

  always_ff @(posedge wclk) begin
    if (w_push) mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  // Write pointer (Gray) into the read domain.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) wgray_r[i] <= '0;
    end else begin
      wgray_r[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_r[i] <= wgray_r[i-1];
    end
  end

  assign wsync_bin    = gray2bin(wgray_r[SYNC_STAGES-1]);
  assign almost_empty = (rd_level <= AE_L);

`ifdef TS_CDC_FIFO_FWFT_EN
  logic          out_valid, out_valid_next, load;
  logic [PW-1:0] mem_cnt;

  // The output register refills from memory whenever it is empty or being
  // consumed. mem_cnt is registered, which adds one rclk of latency but
  // keeps the path from the synchroniser to the RAM address short.
  assign load           = (mem_cnt != '0) && (!out_valid || r_en);
  assign out_valid_next = load || (out_valid && !r_en);
  assign rbin_next      = rbin + PW'(load);
  assign empty          = !out_valid;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin      <= '0;
      rgray     <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      rd_level  <= '0;
      rdata     <= '0;
      underflow <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= bin2gray(rbin_next);
      mem_cnt   <= wsync_bin - rbin_next;
      out_valid <= out_valid_next;
      rd_level  <= (wsync_bin - rbin_next) + PW'(out_valid_next);
      if (load) rdata <= mem[rbin[ADDR_WIDTH-1:0]];
      if (r_en && empty) underflow <= 1'b1;
      else if (udf_clr)  underflow <= 1'b0;
    end
  end
`else
  logic r_pop;

  assign r_pop     = r_en && !empty;
  assign rbin_next = rbin + PW'(r_pop);
  assign empty     = (rd_level == '0);

  // The level uses the post-pop pointer, so empty rises on the edge that
  // pops the last word. The write pointer seen here is stale, which can
  // only make the level look lower than it really is.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin      <= '0;
      rgray     <= '0;
      rd_level  <= '0;
      rdata     <= '0;
      underflow <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rgray    <= bin2gray(rbin_next);
      rd_level <= wsync_bin - rbin_next;
      if (r_pop) rdata <= mem[rbin[ADDR_WIDTH-1:0]];
      if (r_en && empty) underflow <= 1'b1;
      else if (udf_clr)  underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ts_cdc_fifo_lvl.sv
// tb_ts_cdc_fifo_lvl
//   Directed bench for ts_cdc_fifo_lvl (DEPTH=16, SYNC_STAGES=2).
//   wclk period is 24 and rclk period is 38. wclk rising edges fall on even
//   times and rclk rising edges on odd times, so the two never coincide.
module tb_ts_cdc_fifo_lvl;

  logic       wclk, rclk, rst;
  logic       w_en, ovf_clr, r_en, udf_clr;
  logic [9:0] wdata, rdata;
  logic       full, almost_full, overflow, empty, almost_empty, underflow;
  logic [4:0] wr_level, rd_level;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         rcnt   = 0;
  logic       lvl_bad;
  logic [9:0] sb [$];

`ifdef TS_CDC_FIFO_FWFT_EN
  localparam int RD_MAX = 17;
`else
  localparam int RD_MAX = 16;
`endif

  ts_cdc_fifo_lvl dut (
    .wclk         (wclk),
    .rclk         (rclk),
    .rst          (rst),
    .w_en         (w_en),
    .wdata        (wdata),
    .ovf_clr      (ovf_clr),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow),
    .r_en         (r_en),
    .udf_clr      (udf_clr),
    .rdata        (rdata),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  initial begin
    wclk = 1'b0;
    forever #12 wclk = ~wclk;
  end

  initial begin
    rclk = 1'b0;
    forever #19 rclk = ~rclk;
  end

  always @(posedge rclk) rcnt <= rcnt + 1;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic release_reset();
    @(negedge wclk) rst = 1'b0;
    repeat (4) @(negedge rclk);
    repeat (4) @(negedge wclk);
  endtask

  task automatic wait_rd_level(input int lvl);
    for (int k = 0; k < 30; k++) begin
      @(negedge rclk);
      if (rd_level == 5'(lvl)) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_en = 1'b0; wdata = '0; ovf_clr = 1'b0; r_en = 1'b0; udf_clr = 1'b0;
    repeat (3) @(negedge wclk);
    n_cmp++; if (full !== 1'b0)          begin n_fail++; $display("[TB] FAIL rst_full: got %b expected 0", full); end
    n_cmp++; if (almost_full !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_almost_full: got %b expected 0", almost_full); end
    n_cmp++; if (wr_level !== 5'd0)      begin n_fail++; $display("[TB] FAIL rst_wr_level: got %0d expected 0", wr_level); end
    n_cmp++; if (overflow !== 1'b0)      begin n_fail++; $display("[TB] FAIL rst_overflow: got %b expected 0", overflow); end
    n_cmp++; if (empty !== 1'b1)         begin n_fail++; $display("[TB] FAIL rst_empty: got %b expected 1", empty); end
    n_cmp++; if (almost_empty !== 1'b1)  begin n_fail++; $display("[TB] FAIL rst_almost_empty: got %b expected 1", almost_empty); end
    n_cmp++; if (rd_level !== 5'd0)      begin n_fail++; $display("[TB] FAIL rst_rd_level: got %0d expected 0", rd_level); end
    n_cmp++; if (underflow !== 1'b0)     begin n_fail++; $display("[TB] FAIL rst_underflow: got %b expected 0", underflow); end
    n_cmp++; if (rdata !== 10'h000)      begin n_fail++; $display("[TB] FAIL rst_rdata: got %h expected 000", rdata); end
    release_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      @(negedge wclk); w_en = 1'b1; wdata = 10'(i);
      @(posedge wclk); #1;
      n_cmp++; if (wr_level !== 5'(i + 1))        begin n_fail++; $display("[TB] FAIL fill_wr_level[%0d]: got %0d expected %0d", i, wr_level, i + 1); end
      n_cmp++; if (full !== (i == 15))            begin n_fail++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 15)); end
      n_cmp++; if (almost_full !== (i + 1 >= 12)) begin n_fail++; $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 12)); end
    end
    @(negedge wclk); w_en = 1'b1; wdata = 10'h3FF;
    @(posedge wclk); #1;
    n_cmp++; if (overflow !== 1'b1)  begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    n_cmp++; if (wr_level !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_wr_level: got %0d expected 16", wr_level); end
    @(negedge wclk); w_en = 1'b1; ovf_clr = 1'b1;
    @(posedge wclk); #1;
    n_cmp++; if (overflow !== 1'b1)  begin n_fail++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow); end
    @(negedge wclk); w_en = 1'b0; ovf_clr = 1'b1;
    @(posedge wclk); #1;
    n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    @(negedge wclk); ovf_clr = 1'b0;
  endtask

  task automatic test_drain();
    wait_rd_level(16);
    n_cmp++; if (rd_level !== 5'd16) begin n_fail++; $display("[TB] FAIL drain_start_level: got %0d expected 16", rd_level); end
    @(negedge rclk); r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      if (i == 15) r_en = 1'b0;
      n_cmp++; if (rdata !== 10'(i))             begin n_fail++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, rdata, 10'(i)); end
      n_cmp++; if (rd_level !== 5'(15 - i))      begin n_fail++; $display("[TB] FAIL drain_level[%0d]: got %0d expected %0d", i, rd_level, 15 - i); end
      n_cmp++; if (empty !== (i == 15))          begin n_fail++; $display("[TB] FAIL drain_empty[%0d]: got %b expected %b", i, empty, (i == 15)); end
      n_cmp++; if (almost_empty !== (15 - i <= 2)) begin n_fail++; $display("[TB] FAIL drain_almost_empty[%0d]: got %b expected %b", i, almost_empty, (15 - i <= 2)); end
    end
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL udf_set: got %b expected 1", underflow); end
    n_cmp++; if (rdata !== 10'h00F)  begin n_fail++; $display("[TB] FAIL udf_rdata_hold: got %h expected 00f", rdata); end
    @(negedge rclk); udf_clr = 1'b1;
    @(negedge rclk); udf_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL udf_clear: got %b expected 0", underflow); end
    repeat (6) @(negedge wclk);
    n_cmp++; if (wr_level !== 5'd0)  begin n_fail++; $display("[TB] FAIL drain_wr_level: got %0d expected 0", wr_level); end
    n_cmp++; if (full !== 1'b0)      begin n_fail++; $display("[TB] FAIL drain_full: got %b expected 0", full); end
  endtask

  task automatic test_latency();
    int rc0, edges, lo, hi;
`ifdef TS_CDC_FIFO_FWFT_EN
    lo = 4; hi = 5;
`else
    lo = 3; hi = 4;
`endif
    @(negedge wclk); w_en = 1'b1; wdata = 10'h1C3;
    @(posedge wclk); rc0 = rcnt;
    @(negedge wclk); w_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge rclk);
      if (!empty) break;
    end
    edges = rcnt - rc0;
    n_cmp++; if (edges < lo || edges > hi) begin n_fail++; $display("[TB] FAIL latency_edges: got %0d expected %0d..%0d", edges, lo, hi); end
`ifdef TS_CDC_FIFO_FWFT_EN
    n_cmp++; if (rdata !== 10'h1C3) begin n_fail++; $display("[TB] FAIL latency_data: got %h expected 1c3", rdata); end
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
`else
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
    n_cmp++; if (rdata !== 10'h1C3) begin n_fail++; $display("[TB] FAIL latency_data: got %h expected 1c3", rdata); end
`endif
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_wrap();
    int sent, got;
    sent = 0; got = 0; lvl_bad = 1'b0;
    fork
      begin
        for (int cyc = 0; cyc < 4000 && sent < 100; cyc++) begin
          @(negedge wclk);
          if (wr_level > 5'd16) lvl_bad = 1'b1;
          if (!full && $urandom_range(0, 3) != 0) begin
            w_en = 1'b1; wdata = 10'($urandom_range(0, 1023));
            sb.push_back(wdata); sent++;
          end else begin
            w_en = 1'b0;
          end
        end
        @(negedge wclk); w_en = 1'b0;
      end
      begin
        logic       pend;
        logic [9:0] exp;
        pend = 1'b0;
        for (int cyc = 0; cyc < 6000 && got < 100; cyc++) begin
          @(negedge rclk);
          if (rd_level > 5'(RD_MAX)) lvl_bad = 1'b1;
`ifdef TS_CDC_FIFO_FWFT_EN
          if (!empty && $urandom_range(0, 4) < 3) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 10'h000;
            n_cmp++; if (rdata !== exp) begin n_fail++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", got, rdata, exp); end
            got++; r_en = 1'b1;
          end else begin
            r_en = 1'b0;
          end
`else
          if (pend) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 10'h000;
            n_cmp++; if (rdata !== exp) begin n_fail++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", got, rdata, exp); end
            got++;
          end
          pend = 1'b0;
          if (got < 100 && !empty && $urandom_range(0, 4) < 3) begin
            r_en = 1'b1; pend = 1'b1;
          end else begin
            r_en = 1'b0;
          end
`endif
        end
        r_en = 1'b0;
      end
    join
    n_cmp++; if (got != 100)       begin n_fail++; $display("[TB] FAIL wrap_count: got %0d words expected 100", got); end
    n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL wrap_overflow: got %b expected 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_underflow: got %b expected 0", underflow); end
    n_cmp++; if (lvl_bad !== 1'b0)   begin n_fail++; $display("[TB] FAIL wrap_level_bound: got out-of-range expected in-range"); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      @(negedge wclk); w_en = 1'b1; wdata = 10'h100 + 10'(i);
    end
    @(negedge wclk); w_en = 1'b0;
    wait_rd_level(9);
    n_cmp++; if (rd_level !== 5'd9) begin n_fail++; $display("[TB] FAIL mid_pre_level: got %0d expected 9", rd_level); end
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
    n_cmp++; if (rdata !== 10'h100) begin n_fail++; $display("[TB] FAIL mid_pre_data: got %h expected 100", rdata); end
    @(negedge wclk); w_en = 1'b1; wdata = 10'h2FF;
    @(negedge wclk); rst = 1'b1;
    @(posedge wclk); #1;
    w_en = 1'b0;
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("[TB] FAIL mid_empty: got %b expected 1", empty); end
    n_cmp++; if (full !== 1'b0)     begin n_fail++; $display("[TB] FAIL mid_full: got %b expected 0", full); end
    n_cmp++; if (wr_level !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_wr_level: got %0d expected 0", wr_level); end
    n_cmp++; if (rd_level !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_rd_level: got %0d expected 0", rd_level); end
    n_cmp++; if (rdata !== 10'h000) begin n_fail++; $display("[TB] FAIL mid_rdata: got %h expected 000", rdata); end
    release_reset();
    @(negedge wclk); w_en = 1'b1; wdata = 10'h055;
    @(negedge wclk); w_en = 1'b0;
    wait_rd_level(1);
    repeat (2) @(negedge rclk);
    n_cmp++; if (rd_level !== 5'd1) begin n_fail++; $display("[TB] FAIL mid_post_level: got %0d expected 1", rd_level); end
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
    n_cmp++; if (rdata !== 10'h055) begin n_fail++; $display("[TB] FAIL mid_post_data: got %h expected 055", rdata); end
    n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("[TB] FAIL mid_post_empty: got %b expected 1", empty); end
  endtask

`ifdef TS_CDC_FIFO_FWFT_EN
  task automatic test_fwft();
    @(negedge wclk); w_en = 1'b1; wdata = 10'h2A5;
    @(negedge wclk); w_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge rclk);
      if (!empty) break;
    end
    n_cmp++; if (empty !== 1'b0)     begin n_fail++; $display("[TB] FAIL fwft_empty: got %b expected 0", empty); end
    n_cmp++; if (rdata !== 10'h2A5)  begin n_fail++; $display("[TB] FAIL fwft_data: got %h expected 2a5", rdata); end
    n_cmp++; if (rd_level !== 5'd1)  begin n_fail++; $display("[TB] FAIL fwft_level: got %0d expected 1", rd_level); end
    @(negedge rclk); r_en = 1'b1;
    @(negedge rclk); r_en = 1'b0;
    n_cmp++; if (empty !== 1'b1)     begin n_fail++; $display("[TB] FAIL fwft_empty_after: got %b expected 1", empty); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL fwft_underflow: got %b expected 0", underflow); end
    n_cmp++; if (rd_level !== 5'd0)  begin n_fail++; $display("[TB] FAIL fwft_level_after: got %0d expected 0", rd_level); end
  endtask
`endif

  initial begin
    $display("[TB] ts_cdc_fifo_lvl bench start");
    test_reset();
`ifdef TS_CDC_FIFO_FWFT_EN
    test_fwft();
    test_latency();
`else
    test_fill();
    test_drain();
    test_latency();
    test_wrap();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
